// File: rtl/csr_cmd_master.sv
// csr_cmd_master: single-outstanding Avalon-MM master for the CSR bus.
// Optional statistics counters enabled by CSR_CMD_MASTER_STATS_EN.
module csr_cmd_master #(
  parameter int ADDR_W         = 20,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              csr_clk_clk,
  input  logic              csr_clk_reset_reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_writedata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic              rsp_error,
  output logic [DATA_W-1:0] rsp_readdata,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_read,
  output logic              master_write,
  output logic [DATA_W-1:0] master_writedata,
  input  logic [DATA_W-1:0] master_readdata,
  input  logic              master_waitrequest,
  output logic [31:0]       stat_txn_count,
  output logic [15:0]       stat_timeout_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [15:0] TO_LAST =
    16'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_W-1:0] TO_DATA =
    DATA_W'(32'hDEADC0DE);

  logic              clk;
  logic              rst;
  logic [1:0]        state;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [15:0]       stall_cnt;
  logic              rsp_write_q;
  logic              rsp_error_q;
  logic [DATA_W-1:0] rsp_data_q;

  logic in_idle;
  logic in_bus;
  logic in_resp;
  logic accept;
  logic done;
  logic abort;
  logic rsp_hs;

  assign clk = csr_clk_clk;
  assign rst = csr_clk_reset_reset;

  assign in_idle = (state == S_IDLE);
  assign in_bus  = (state == S_BUS);
  assign in_resp = (state == S_RESP);

  assign accept = in_idle && cmd_valid;
  assign done   = in_bus && !master_waitrequest;
  // Abort on the TIMEOUT_CYCLES-th consecutive stalled cycle.
  assign abort  = in_bus && master_waitrequest &&
                  (stall_cnt == TO_LAST);
  assign rsp_hs = in_resp && rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      stall_cnt   <= '0;
      rsp_write_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            wr_q      <= cmd_write;
            addr_q    <= cmd_address;
            wdata_q   <= cmd_writedata;
            stall_cnt <= '0;
            state     <= S_BUS;
          end
        end
        S_BUS: begin
          if (done) begin
            rsp_write_q <= wr_q;
            rsp_error_q <= 1'b0;
            rsp_data_q  <= wr_q ? '0 : master_readdata;
            state       <= S_RESP;
          end else if (abort) begin
            rsp_write_q <= wr_q;
            rsp_error_q <= 1'b1;
            rsp_data_q  <= wr_q ? '0 : TO_DATA;
            state       <= S_RESP;
          end else begin
            stall_cnt <= stall_cnt + 16'd1;
          end
        end
        S_RESP: begin
          if (rsp_hs) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Ready is forced low while reset is held, even though state is IDLE.
  assign cmd_ready = in_idle && !rst;

  assign master_address   = addr_q;
  assign master_writedata = wdata_q;
  assign master_read      = in_bus && !wr_q;
  assign master_write     = in_bus && wr_q;

  assign rsp_valid    = in_resp;
  assign rsp_write    = rsp_write_q;
  assign rsp_error    = rsp_error_q;
  assign rsp_readdata = rsp_data_q;

`ifdef CSR_CMD_MASTER_STATS_EN
  logic [31:0] txn_q;
  logic [15:0] to_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      txn_q <= '0;
      to_q  <= '0;
    end else begin
      if (rsp_hs) begin
        txn_q <= txn_q + 32'd1;
      end
      if (abort && (to_q != 16'hFFFF)) begin
        to_q <= to_q + 16'd1;
      end
    end
  end

  assign stat_txn_count     = txn_q;
  assign stat_timeout_count = to_q;
`else
  assign stat_txn_count     = 32'd0;
  assign stat_timeout_count = 16'd0;
`endif

endmodule

// File: tb/tb_csr_cmd_master.sv
// tb_csr_cmd_master: vector table, corner sequences and random run
// for csr_cmd_master with TIMEOUT_CYCLES=8.
module tb_csr_cmd_master;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [19:0] cmd_address = '0;
  logic [31:0] cmd_writedata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_write;
  logic        rsp_error;
  logic [31:0] rsp_readdata;
  logic [19:0] master_address;
  logic        master_read;
  logic        master_write;
  logic [31:0] master_writedata;
  logic [31:0] master_readdata = '0;
  logic        master_waitrequest = 1'b0;
  logic [31:0] stat_txn_count;
  logic [15:0] stat_timeout_count;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int exp_txn = 0;
  int exp_to = 0;

  csr_cmd_master #(
    .ADDR_W(20),
    .DATA_W(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .csr_clk_clk(clk),
    .csr_clk_reset_reset(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_address(cmd_address),
    .cmd_writedata(cmd_writedata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_write(rsp_write),
    .rsp_error(rsp_error),
    .rsp_readdata(rsp_readdata),
    .master_address(master_address),
    .master_read(master_read),
    .master_write(master_write),
    .master_writedata(master_writedata),
    .master_readdata(master_readdata),
    .master_waitrequest(master_waitrequest),
    .stat_txn_count(stat_txn_count),
    .stat_timeout_count(stat_timeout_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        wr;
    logic [19:0] addr;
    logic [31:0] wdata;
    int          stalls;
    logic [31:0] rdata;
    int          exp_strobes;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] stats_exp();
`ifdef CSR_CMD_MASTER_STATS_EN
    return {1'b1, 32'(exp_txn)};
`else
    return 33'd0;
`endif
  endfunction

  task automatic check_stats(input string tag);
    logic [31:0] et;
    logic [31:0] eo;
`ifdef CSR_CMD_MASTER_STATS_EN
    et = 32'(exp_txn);
    eo = 32'(exp_to);
`else
    et = 32'd0;
    eo = 32'd0;
`endif
    check({tag, "_txn_cnt"}, stat_txn_count, et);
    check({tag, "_to_cnt"}, {16'd0, stat_timeout_count}, eo);
  endtask

  function automatic logic [31:0] slave_data(input logic [19:0] a);
    return {a[11:0], a} ^ 32'h5A0F_3C96;
  endfunction

  // Called at a negedge; returns at the negedge where rsp_valid is seen.
  // stalls < 0 means waitrequest stuck high.
  task automatic run_cmd(input logic wr,
                         input logic [19:0] addr,
                         input logic [31:0] wdata,
                         input int stalls,
                         input logic [31:0] rdata,
                         output int strobes,
                         output int lat,
                         output int bad_bus);
    int t;
    cmd_write     = wr;
    cmd_address   = addr;
    cmd_writedata = wdata;
    cmd_valid     = 1'b1;
    t = 0;
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      fails++;
      $display("FAIL accept_timeout: got no cmd_ready expected accept");
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    strobes = 0;
    bad_bus = 0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      if (master_read || master_write) begin
        strobes++;
        if (master_read && master_write) bad_bus++;
        if (master_write !== wr) bad_bus++;
        if (master_address !== addr) bad_bus++;
        if (wr && master_writedata !== wdata) bad_bus++;
      end
      master_waitrequest = (stalls < 0) || ((lat - 1) < stalls);
      master_readdata = rdata;
      @(negedge clk);
      lat++;
    end
    master_waitrequest = 1'b0;
    if (!rsp_valid) begin
      fails++;
      $display("FAIL rsp_timeout: got no rsp_valid expected response");
    end
  endtask

  vec_t vecs[5];

  initial begin
    int strobes, lat, bad;
    logic [31:0] sd;
    logic        sw;
    logic        se;
    int          bp_bad;
    int          t0;
    logic [32:0] unused_se;

    vecs[0] = '{1'b0, 20'h00400, 32'h0, 0, 32'h12345678,
                1, 2, 1'b0, 32'h12345678};
    vecs[1] = '{1'b1, 20'h9FFFC, 32'hA5A5A5A5, 3, 32'hFFFFFFFF,
                4, 5, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 20'h01230, 32'h0, -1, 32'h11111111,
                8, 9, 1'b1, 32'hDEADC0DE};
    vecs[3] = '{1'b0, 20'h04444, 32'h0, 7, 32'hCAFEF00D,
                8, 9, 1'b0, 32'hCAFEF00D};
    vecs[4] = '{1'b1, 20'h00010, 32'h77777777, -1, 32'h22222222,
                8, 9, 1'b1, 32'h0};
    unused_se = stats_exp();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_strobes", {30'd0, master_read, master_write}, 32'd0);
    check("rst_master_addr", {12'd0, master_address}, 32'd0);
    check("rst_master_wdata", master_writedata, 32'd0);
    check("rst_rsp_fields", {30'd0, rsp_write, rsp_error}, 32'd0);
    check("rst_rsp_data", rsp_readdata, 32'd0);
    check_stats("rst");
    rst = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);

    // Table of single transactions
    for (int i = 0; i < 5; i++) begin
      run_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata,
              vecs[i].stalls, vecs[i].rdata, strobes, lat, bad);
      check($sformatf("v%0d_strobes", i), 32'(strobes),
            32'(vecs[i].exp_strobes));
      check($sformatf("v%0d_latency", i), 32'(lat),
            32'(vecs[i].exp_lat));
      check($sformatf("v%0d_bus", i), 32'(bad), 32'd0);
      check($sformatf("v%0d_write", i), {31'd0, rsp_write},
            {31'd0, vecs[i].wr});
      check($sformatf("v%0d_error", i), {31'd0, rsp_error},
            {31'd0, vecs[i].exp_err});
      check($sformatf("v%0d_data", i), rsp_readdata,
            vecs[i].exp_data);
      exp_txn++;
      if (vecs[i].exp_err) exp_to++;
    end
    @(negedge clk);
    check_stats("table");

    // Backpressure: hold response 10 cycles with a pending command
    rsp_ready = 1'b0;
    run_cmd(1'b0, 20'h0ABCD, 32'h0, 0, 32'hBEEF1234,
            strobes, lat, bad);
    sd = rsp_readdata;
    sw = rsp_write;
    se = rsp_error;
    check("bp_data", sd, 32'hBEEF1234);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_address = 20'h00FF0;
    bp_bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!rsp_valid || cmd_ready) bp_bad++;
      if (master_read || master_write) bp_bad++;
      if (rsp_readdata !== sd || rsp_write !== sw ||
          rsp_error !== se) bp_bad++;
    end
    check("bp_hold", 32'(bp_bad), 32'd0);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    exp_txn++;
    check("bp_release", {30'd0, rsp_valid, cmd_ready}, 32'd1);
    check_stats("bp");

    // Reset during the 2nd stall cycle
    cmd_write = 1'b1;
    cmd_address = 20'h00200;
    cmd_writedata = 32'h13579BDF;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    master_waitrequest = 1'b1;
    check("mid_strobe1", {31'd0, master_write}, 32'd1);
    @(negedge clk);
    check("mid_strobe2", {31'd0, master_write}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_out",
          {28'd0, master_read, master_write, rsp_valid, cmd_ready},
          32'd0);
    rst = 1'b0;
    master_waitrequest = 1'b0;
    exp_txn = 0;
    exp_to = 0;
    #1;
    check("mid_rel_ready", {31'd0, cmd_ready}, 32'd1);
    bp_bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid || master_read || master_write) bp_bad++;
    end
    check("mid_no_rsp", 32'(bp_bad), 32'd0);
    check_stats("mid");

    // 100 random back-to-back commands, zero-wait slave
    t0 = cyc;
    for (int n = 0; n < 100; n++) begin
      logic        w;
      logic [19:0] a;
      logic [31:0] d;
      logic [31:0] rd;
      w  = 1'($urandom_range(0, 1));
      a  = 20'($urandom);
      d  = $urandom;
      rd = slave_data(a);
      run_cmd(w, a, d, 0, rd, strobes, lat, bad);
      check($sformatf("r%0d_bus", n), 32'(bad + strobes), 32'd1);
      check($sformatf("r%0d_rsp", n),
            {30'd0, rsp_write, rsp_error}, {30'd0, w, 1'b0});
      check($sformatf("r%0d_data", n), rsp_readdata,
            w ? 32'd0 : rd);
      exp_txn++;
    end
    check("rand_cycles", 32'(cyc - t0), 32'd299);
    @(negedge clk);
    check_stats("rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

endmodule
